// File: rtl/bcd7seg_pkg.sv
// Shared types, segment constants and the active-high BCD decode function
// for the multiplexed 7-segment display driver.
package bcd7seg_pkg;

    typedef logic [6:0] seg_t;   // {a,b,c,d,e,f,g}

    localparam seg_t SEG_0     = 7'h7E;
    localparam seg_t SEG_1     = 7'h30;
    localparam seg_t SEG_2     = 7'h6D;
    localparam seg_t SEG_3     = 7'h79;
    localparam seg_t SEG_4     = 7'h33;
    localparam seg_t SEG_5     = 7'h5B;
    localparam seg_t SEG_6     = 7'h5F;
    localparam seg_t SEG_7     = 7'h70;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h7B;
    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t seg_decode(input logic [3:0] bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;   // non-BCD codes stay dark
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd7seg_decode_ah.sv
// Combinational active-high BCD to 7-segment decoder; polarity is applied
// downstream at the output registers.
module bcd7seg_decode_ah
    import bcd7seg_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    // Pure table lookup
    always_comb begin
        seg = seg_decode(bcd);
    end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit BCD to 7-segment scan driver with frame-aligned
// shadow/active swap. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_7seg_scan_driver
    import bcd7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_DIG = 1
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = '0;
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    // XOR masks: the inactive level of each output, also used to invert lit values
    localparam seg_t                  SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW_DIG != 0) ? {NUM_DIGITS{1'b1}}
                                                                       : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]        presc_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [4*NUM_DIGITS-1:0] active_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [NUM_DIGITS-1:0]   active_dp_r;
    logic                    pending_r;
    logic [NUM_DIGITS-1:0]   blank_s;

    seg_t                    seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   dig_en_r;
    logic                    frame_tick_r;

    logic                    term_s;
    logic                    wrap_s;
    logic                    swap_s;
    logic [3:0]              digit_s;
    logic                    dp_sel_s;
    logic                    blank_sel_s;
    logic [NUM_DIGITS-1:0]   dig_oh_s;
    seg_t                    seg_ah_s;
    seg_t                    seg_lit_s;

    assign term_s = enable && (presc_r == PRE_LAST);
    assign wrap_s = term_s && (idx_r == IDX_LAST);
    assign swap_s = wrap_s && pending_r;

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i (i>0) is blanked when it and every digit above it are zero
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (v[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            m[i] = ~seen;
        end
        return m;
    endfunction

    logic [NUM_DIGITS-1:0] blank_r;

    // Blank mask tracks the active register, refreshed only at a frame swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_r <= lz_mask('0);
        end else if (swap_s) begin
            blank_r <= lz_mask(shadow_r);
        end else begin
            blank_r <= blank_r;
        end
    end

    assign blank_s = blank_r;
`else
    assign blank_s = '0;
`endif

    // Prescaler, scan index and wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r      <= PRE_ZERO;
            idx_r        <= IDX_ZERO;
            frame_tick_r <= 1'b0;
        end else begin
            if (!enable) begin
                presc_r <= PRE_ZERO;
                idx_r   <= IDX_ZERO;
            end else if (term_s) begin
                presc_r <= PRE_ZERO;
                idx_r   <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IDX_ONE;
            end else begin
                presc_r <= presc_r + PRE_ONE;
                idx_r   <= idx_r;
            end
            frame_tick_r <= wrap_s;
        end
    end

    // Shadow capture and frame-aligned swap; a load coinciding with the wrap keeps pending set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r    <= '0;
            shadow_dp_r <= '0;
            active_r    <= '0;
            active_dp_r <= '0;
            pending_r   <= 1'b0;
        end else begin
            if (load) begin
                shadow_r    <= bcd_in;
                shadow_dp_r <= dp_in;
                pending_r   <= 1'b1;
            end else if (swap_s) begin
                pending_r   <= 1'b0;
            end else begin
                pending_r   <= pending_r;
            end
            if (swap_s) begin
                active_r    <= shadow_r;
                active_dp_r <= shadow_dp_r;
            end else begin
                active_r    <= active_r;
                active_dp_r <= active_dp_r;
            end
        end
    end

    // Select the current digit, its dp, blank flag and one-hot enable
    always_comb begin
        digit_s     = 4'd0;
        dp_sel_s    = 1'b0;
        blank_sel_s = 1'b0;
        dig_oh_s    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                digit_s     = active_r[4*i +: 4];
                dp_sel_s    = active_dp_r[i];
                blank_sel_s = blank_s[i];
                dig_oh_s[i] = 1'b1;
            end else begin
                dig_oh_s[i] = 1'b0;
            end
        end
        seg_lit_s = blank_sel_s ? SEG_BLANK : seg_ah_s;
    end

    bcd7seg_decode_ah u_decode (
        .bcd (digit_s),
        .seg (seg_ah_s)
    );

    // Output registers: dark slot while prescaler is 0 or scan disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r    <= SEG_OFF;
            dp_r     <= DP_OFF;
            dig_en_r <= DIG_OFF;
        end else if (!enable || (presc_r == PRE_ZERO)) begin
            seg_r    <= SEG_OFF;
            dp_r     <= DP_OFF;
            dig_en_r <= DIG_OFF;
        end else begin
            seg_r    <= seg_lit_s ^ SEG_OFF;
            dp_r     <= dp_sel_s ^ DP_OFF;
            dig_en_r <= dig_oh_s ^ DIG_OFF;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign dig_en     = dig_en_r;
    assign frame_tick = frame_tick_r;

endmodule
